// File: rtl/md_issue_ctrl.sv
// Issue front end for the multiply/divide unit: buffers one E-stage request,
// issues it as a one-cycle start pulse, then tracks MDU busy and stalls mfhi/mflo.
module md_issue_ctrl #(
  parameter int         TIMEOUT  = 16,
  parameter logic [3:0] OP_MULT  = 4'd1,
  parameter logic [3:0] OP_MULTU = 4'd2,
  parameter logic [3:0] OP_DIV   = 4'd3,
  parameter logic [3:0] OP_DIVU  = 4'd4,
  parameter logic [3:0] OP_MTHI  = 4'd5,
  parameter logic [3:0] OP_MTLO  = 4'd6,
  parameter logic [3:0] OP_FDIV  = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        start,
  output logic [3:0]  mlu_op,
  output logic [31:0] D1,
  output logic [31:0] D2,
  input  logic        mlu_busy,
  input  logic [31:0] mlu_hi,
  input  logic [31:0] mlu_lo,
  input  logic        rd_valid,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_stall,
  output logic        div0,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic               buf_v;
  logic [3:0]         buf_op;
  logic [31:0]        buf_a;
  logic [31:0]        buf_b;
  logic [CNT_W-1:0]   wait_cnt;

  logic accept;
  logic buf_known;
  logic buf_is_div;
  logic issue_is_move;

  assign req_ready     = !buf_v;
  assign accept        = req_valid && req_ready;
  assign buf_known     = buf_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                                        OP_MTHI, OP_MTLO, OP_FDIV};
  assign buf_is_div    = buf_op inside {OP_DIV, OP_DIVU, OP_FDIV};
  assign issue_is_move = (mlu_op == OP_MTHI) || (mlu_op == OP_MTLO);

  // A request accepted this very edge is older than the read, so the read waits.
  assign rd_stall = rd_valid && (buf_v || (state != IDLE) || accept);
  assign rd_data  = rd_sel ? mlu_hi : mlu_lo;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      buf_v       <= 1'b0;
      buf_op      <= '0;
      buf_a       <= '0;
      buf_b       <= '0;
      wait_cnt    <= '0;
      start       <= 1'b0;
      mlu_op      <= '0;
      D1          <= '0;
      D2          <= '0;
      div0        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start  <= 1'b0;
      mlu_op <= '0;
      div0   <= 1'b0;

      // Capture only when empty; consumption below only when full.
      if (accept) begin
        buf_v  <= 1'b1;
        buf_op <= req_op;
        buf_a  <= req_a;
        buf_b  <= req_b;
      end

      unique case (state)
        IDLE: begin
          if (buf_v && !mlu_busy) begin
            buf_v <= 1'b0;
            if (!buf_known) begin
              // unknown or zero op code: dropped silently
            end else if (buf_is_div && (buf_b == '0)) begin
              div0 <= 1'b1;
            end else begin
              state  <= ISSUE;
              start  <= 1'b1;
              mlu_op <= buf_op;
              D1     <= buf_a;
              D2     <= buf_b;
            end
          end
        end

        ISSUE: begin
          // The MDU writes HI/LO for moves at this edge, so nothing to wait on.
          if (issue_is_move) begin
            state <= IDLE;
          end else begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end

        WAIT: begin
          if (!mlu_busy) begin
            state <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural MDU model that
// produces HI/LO and busy; expected values are hand-computed constants.
module tb_md_issue_ctrl;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_FDIV  = 4'd7;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        start;
  logic [3:0]  mlu_op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        mlu_busy;
  logic [31:0] mlu_hi;
  logic [31:0] mlu_lo;
  logic        rd_valid;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        div0;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .start(start), .mlu_op(mlu_op), .D1(D1), .D2(D2),
    .mlu_busy(mlu_busy), .mlu_hi(mlu_hi), .mlu_lo(mlu_lo),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_data(rd_data), .rd_stall(rd_stall),
    .div0(div0), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MDU model: samples start, holds busy for a fixed latency, then commits HI/LO.
  // With hang_mode set, an arithmetic op keeps busy high until hang_mode drops.
  logic [3:0]  m_cnt;
  logic [31:0] p_hi, p_lo;
  logic        stuck;
  logic        hang_mode;
  logic [63:0] mul_s, mul_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign mul_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
  assign mul_u = {32'b0, D1} * {32'b0, D2};
  assign q_s   = (D2 == 32'd0) ? 32'd0 : 32'($signed(D1) / $signed(D2));
  assign r_s   = (D2 == 32'd0) ? 32'd0 : 32'($signed(D1) % $signed(D2));
  assign q_u   = (D2 == 32'd0) ? 32'd0 : D1 / D2;
  assign r_u   = (D2 == 32'd0) ? 32'd0 : D1 % D2;
  assign mlu_busy = (m_cnt != 4'd0) || stuck;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= 4'd0;
      mlu_hi <= 32'd0;
      mlu_lo <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      stuck  <= 1'b0;
    end else begin
      if (!hang_mode) stuck <= 1'b0;
      if (m_cnt == 4'd1) begin
        mlu_hi <= p_hi;
        mlu_lo <= p_lo;
      end
      if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
      if (start) begin
        case (mlu_op)
          OP_MULT:  begin {p_hi, p_lo} <= mul_s; m_cnt <= 4'd4; end
          OP_MULTU: begin {p_hi, p_lo} <= mul_u; m_cnt <= 4'd4; end
          OP_DIV:   begin p_hi <= r_s; p_lo <= q_s; m_cnt <= 4'd9; end
          OP_DIVU:  begin p_hi <= r_u; p_lo <= q_u; m_cnt <= 4'd9; end
          OP_FDIV:  begin p_hi <= r_s; p_lo <= q_s; m_cnt <= 4'd2; end
          OP_MTHI:  mlu_hi <= D1;
          OP_MTLO:  mlu_lo <= D1;
          default:  ;
        endcase
        if (hang_mode && (mlu_op != OP_MTHI) && (mlu_op != OP_MTLO)) stuck <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle right after capture.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    #1;
    check("send_ready", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    req_op    = 4'd0;
  endtask

  task automatic wait_unstall(input int budget, input string tag);
    int n = 0;
    #1;
    while (rd_stall && n < budget) begin
      cyc();
      #1;
      n++;
    end
    check(tag, 32'(rd_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0;
    rd_valid = 1'b0; rd_sel = 1'b0; hang_mode = 1'b0;
    repeat (3) cyc();
    reset = 1'b0; rd_valid = 1'b1; rd_sel = 1'b1;
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_op", 32'(mlu_op), 32'd0);
    check("rst_d1", D1, 32'd0);
    check("rst_d2", D2, 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(rd_stall), 32'd0);
    rd_valid = 1'b0;
    cyc();

    // mult -2 * 3: start only in cycle 1, read stalled through cycle 6
    send(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    check("mult_full", 32'(req_ready), 32'd0);
    check("mult_c0_start", 32'(start), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      rd_valid = 1'b1; rd_sel = 1'b1;
      #1;
      check("mult_stall", 32'(rd_stall), 32'd1);
      check("mult_start", 32'(start), 32'(c == 1));
      if (c == 1) begin
        check("mult_op", 32'(mlu_op), 32'(OP_MULT));
        check("mult_d1", D1, 32'hFFFF_FFFE);
        check("mult_d2", D2, 32'd3);
      end
    end
    cyc();
    #1;
    check("mult_c7_stall", 32'(rd_stall), 32'd0);
    check("mult_hi", rd_data, 32'hFFFF_FFFF);
    rd_sel = 1'b0;
    #1;
    check("mult_lo", rd_data, 32'hFFFF_FFFA);
    check("mult_op_idle", 32'(mlu_op), 32'd0);
    check("mult_d1_hold", D1, 32'hFFFF_FFFE);
    rd_valid = 1'b0;

    // divu 100/7 with an immediate mflo: stalled until cycle 12
    send(OP_DIVU, 32'd100, 32'd7);
    rd_valid = 1'b1; rd_sel = 1'b0;
    #1;
    check("divu_c0_stall", 32'(rd_stall), 32'd1);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      #1;
      check("divu_stall", 32'(rd_stall), 32'd1);
    end
    cyc();
    #1;
    check("divu_c12_stall", 32'(rd_stall), 32'd0);
    check("divu_lo", rd_data, 32'd14);
    rd_sel = 1'b1;
    #1;
    check("divu_hi", rd_data, 32'd2);
    rd_valid = 1'b0;

    // second request captured during WAIT; it issues only after busy falls
    send(OP_DIVU, 32'd100, 32'd7);
    cyc();
    #1;
    check("ovl_start1", 32'(start), 32'd1);
    for (int c = 2; c <= 12; c++) begin
      cyc();
      if (c == 3) begin
        req_valid = 1'b1; req_op = OP_MULTU; req_a = 32'd5; req_b = 32'd6;
      end
      if (c == 4) begin
        req_valid = 1'b0; req_op = 4'd0;
      end
      #1;
      if (c == 3) check("ovl_ready_wait", 32'(req_ready), 32'd1);
      if (c == 4) check("ovl_full", 32'(req_ready), 32'd0);
      check("ovl_no_start", 32'(start), 32'd0);
    end
    cyc();
    #1;
    check("ovl_start2", 32'(start), 32'd1);
    check("ovl_op2", 32'(mlu_op), 32'(OP_MULTU));
    rd_valid = 1'b1; rd_sel = 1'b0;
    wait_unstall(40, "ovl_unstall");
    check("ovl_lo", rd_data, 32'd30);
    rd_sel = 1'b1;
    #1;
    check("ovl_hi", rd_data, 32'd0);
    rd_valid = 1'b0;

    // fdiv -7/2: unstalled from cycle 5, quotient -3 remainder -1
    send(OP_FDIV, 32'hFFFF_FFF9, 32'd2);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      rd_valid = 1'b1; rd_sel = 1'b0;
      #1;
      check("fdiv_stall", 32'(rd_stall), 32'd1);
    end
    cyc();
    #1;
    check("fdiv_c5_stall", 32'(rd_stall), 32'd0);
    check("fdiv_lo", rd_data, 32'hFFFF_FFFD);
    rd_sel = 1'b1;
    #1;
    check("fdiv_hi", rd_data, 32'hFFFF_FFFF);
    rd_valid = 1'b0;

    // divide by zero: dropped, div0 pulses once, HI/LO untouched
    send(OP_DIV, 32'd5, 32'd0);
    #1;
    check("dz_c0_start", 32'(start), 32'd0);
    cyc();
    #1;
    check("dz_div0", 32'(div0), 32'd1);
    check("dz_start", 32'(start), 32'd0);
    check("dz_ready", 32'(req_ready), 32'd1);
    rd_valid = 1'b1; rd_sel = 1'b1;
    #1;
    check("dz_stall", 32'(rd_stall), 32'd0);
    check("dz_hi", rd_data, 32'hFFFF_FFFF);
    rd_sel = 1'b0;
    #1;
    check("dz_lo", rd_data, 32'hFFFF_FFFD);
    rd_valid = 1'b0;
    cyc();
    #1;
    check("dz_div0_off", 32'(div0), 32'd0);
    check("dz_start2", 32'(start), 32'd0);

    // unknown op code: dropped without a start or div0
    send(4'd9, 32'd1, 32'd1);
    cyc();
    #1;
    check("unk_start", 32'(start), 32'd0);
    check("unk_div0", 32'(div0), 32'd0);
    check("unk_ready", 32'(req_ready), 32'd1);

    // mthi then mfhi: readable in cycle 2 with no WAIT
    send(OP_MTHI, 32'h1234_5678, 32'd0);
    cyc();
    rd_valid = 1'b1; rd_sel = 1'b1;
    #1;
    check("mthi_start", 32'(start), 32'd1);
    check("mthi_c1_stall", 32'(rd_stall), 32'd1);
    cyc();
    #1;
    check("mthi_c2_stall", 32'(rd_stall), 32'd0);
    check("mthi_hi", rd_data, 32'h1234_5678);
    rd_valid = 1'b0;

    // timeout: busy never drops; abort after 16 WAIT cycles
    hang_mode = 1'b1;
    send(OP_MULT, 32'd2, 32'd3);
    for (int c = 1; c <= 17; c++) begin
      cyc();
      if (c == 5) begin
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd7; req_b = 32'd8;
      end
      if (c == 6) begin
        req_valid = 1'b0; req_op = 4'd0;
      end
      #1;
      check("tmo_clear", 32'(timeout_err), 32'd0);
    end
    cyc();
    #1;
    check("tmo_set", 32'(timeout_err), 32'd1);
    check("tmo_start", 32'(start), 32'd0);
    for (int c = 19; c <= 21; c++) begin
      cyc();
      #1;
      check("tmo_held_start", 32'(start), 32'd0);
      check("tmo_held_full", 32'(req_ready), 32'd0);
    end
    hang_mode = 1'b0;
    cyc();
    #1;
    check("tmo_c22_start", 32'(start), 32'd0);
    cyc();
    #1;
    check("tmo_issue", 32'(start), 32'd1);
    check("tmo_issue_d1", D1, 32'd7);
    rd_valid = 1'b1; rd_sel = 1'b0;
    wait_unstall(40, "tmo_unstall");
    check("tmo_lo", rd_data, 32'd56);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    rd_valid = 1'b0;

    // reset in cycle 5 of a div, then a fresh mult 7*9
    send(OP_DIV, 32'd100, 32'd7);
    for (int c = 1; c <= 5; c++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_valid = 1'b1; rd_sel = 1'b0;
    #1;
    check("rmid_stall", 32'(rd_stall), 32'd0);
    check("rmid_ready", 32'(req_ready), 32'd1);
    check("rmid_start", 32'(start), 32'd0);
    check("rmid_op", 32'(mlu_op), 32'd0);
    check("rmid_d1", D1, 32'd0);
    check("rmid_d2", D2, 32'd0);
    check("rmid_tmo", 32'(timeout_err), 32'd0);
    check("rmid_div0", 32'(div0), 32'd0);
    rd_valid = 1'b0;
    send(OP_MULT, 32'd7, 32'd9);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      rd_valid = 1'b1; rd_sel = 1'b0;
      #1;
      check("rmult_stall", 32'(rd_stall), 32'd1);
    end
    cyc();
    #1;
    check("rmult_c7_stall", 32'(rd_stall), 32'd0);
    check("rmult_lo", rd_data, 32'd63);
    rd_sel = 1'b1;
    #1;
    check("rmult_hi", rd_data, 32'd0);
    rd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
